tail_light_monitor: RTL and testbench

- Receive-side checker for the six-lamp dimmed tail-light bus; the consumer end of the `light[5:0]` interface driven by the tail-light controller.
- Samples the lamp bus on a single clock and measures per-lamp duty over a fixed window, classifying each lamp as OFF, DIM or ON.
- Decodes the turn sequence (direction and phase) and flags illegal frames or illegal sequence transitions.
- Used in-system as a self-check and on the bench as a scoreboard front end.

---
 rtl/tail_light_monitor.sv | 172 +++++++++++++++++
 tb/tb_tail_light_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tail_light_monitor.sv
// Tail-light bus checker: per-lamp duty over WINDOW samples -> OFF/DIM/ON, turn-sequence decode, error tracking.
// Latency: one cycle from a window's last sample to frame_valid; no backpressure, samples every cycle.
// Optional TAIL_DIM_CHECK_EN adds dim_fault (unlit lamps must glow dim).
module tail_light_monitor #(
    parameter int WINDOW     = 16,
    parameter int ON_THRESH  = 12,
    parameter int DIM_THRESH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  light,
    input  logic        err_clr,
    output logic        frame_valid,
    output logic [11:0] lamp_state,
    output logic        left_active,
    output logic        right_active,
    output logic [1:0]  phase,
    output logic        seq_error,
`ifdef TAIL_DIM_CHECK_EN
    output logic [7:0]  error_count,
    output logic        dim_fault
`else
    output logic [7:0]  error_count
`endif
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int WW = $clog2(WINDOW);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [CW-1:0] ON_T     = CW'(ON_THRESH);
    localparam logic [CW-1:0] DIM_T    = CW'(DIM_THRESH);
    localparam logic [1:0] CLS_OFF = 2'b00;
    localparam logic [1:0] CLS_DIM = 2'b01;
    localparam logic [1:0] CLS_ON  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3
    } state_t;

    logic [WW-1:0] win_cnt;
    logic [CW-1:0] lamp_cnt [6];
    logic [CW-1:0] cnt_nxt  [6];
    logic [1:0]    cls      [6];
    logic [11:0]   cls_vec;
    logic [5:0]    on_set;
    logic          win_end;
    state_t        state;
    state_t        frame_state;
    logic          frame_ok;
    logic          trans_ok;
    logic          err_evt;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            ST_L1, ST_R1: phase_of = 2'd1;
            ST_L2, ST_R2: phase_of = 2'd2;
            ST_L3, ST_R3: phase_of = 2'd3;
            default:      phase_of = 2'd0;
        endcase
    endfunction

    // Classification includes the sample arriving on the window's last cycle.
    always_comb begin
        win_end = (win_cnt == WIN_LAST);
        cls_vec = '0;
        on_set  = '0;
        for (int i = 0; i < 6; i++) begin
            cnt_nxt[i] = lamp_cnt[i] + CW'(light[i]);
            cls[i]     = CLS_OFF;
            if (cnt_nxt[i] >= ON_T)
                cls[i] = CLS_ON;
            else if (cnt_nxt[i] >= DIM_T)
                cls[i] = CLS_DIM;
            cls_vec[2*i +: 2] = cls[i];
            on_set[i]         = (cls[i] == CLS_ON);
        end
    end

    // Only fully lit lamps form the frame; DIM reads as unlit.
    always_comb begin
        frame_ok    = 1'b1;
        frame_state = ST_IDLE;
        case (on_set)
            6'b000000: frame_state = ST_IDLE;
            6'b001000: frame_state = ST_L1;
            6'b011000: frame_state = ST_L2;
            6'b111000: frame_state = ST_L3;
            6'b000100: frame_state = ST_R1;
            6'b000110: frame_state = ST_R2;
            6'b000111: frame_state = ST_R3;
            default:   frame_ok    = 1'b0;
        endcase
    end

    always_comb begin
        trans_ok = 1'b0;
        if (frame_state == ST_IDLE || frame_state == state) begin
            trans_ok = 1'b1;
        end else begin
            case (state)
                ST_IDLE: trans_ok = (frame_state == ST_L1) || (frame_state == ST_R1);
                ST_L1:   trans_ok = (frame_state == ST_L2);
                ST_L2:   trans_ok = (frame_state == ST_L3);
                ST_R1:   trans_ok = (frame_state == ST_R2);
                ST_R2:   trans_ok = (frame_state == ST_R3);
                default: trans_ok = 1'b0;
            endcase
        end
        err_evt = win_end && !(frame_ok && trans_ok);
    end

`ifdef TAIL_DIM_CHECK_EN
    logic any_off;
    always_comb begin
        any_off = 1'b0;
        for (int i = 0; i < 6; i++)
            if (cls[i] == CLS_OFF)
                any_off = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt      <= '0;
            for (int i = 0; i < 6; i++)
                lamp_cnt[i] <= '0;
            state        <= ST_IDLE;
            frame_valid  <= 1'b0;
            lamp_state   <= '0;
            left_active  <= 1'b0;
            right_active <= 1'b0;
            phase        <= 2'd0;
            seq_error    <= 1'b0;
            error_count  <= 8'd0;
`ifdef TAIL_DIM_CHECK_EN
            dim_fault    <= 1'b0;
`endif
        end else begin
            frame_valid <= win_end;
            if (win_end) begin
                win_cnt <= '0;
                for (int i = 0; i < 6; i++)
                    lamp_cnt[i] <= '0;
                state        <= frame_state;
                lamp_state   <= cls_vec;
                left_active  <= (frame_state inside {ST_L1, ST_L2, ST_L3});
                right_active <= (frame_state inside {ST_R1, ST_R2, ST_R3});
                phase        <= phase_of(frame_state);
`ifdef TAIL_DIM_CHECK_EN
                dim_fault    <= frame_ok && any_off;
`endif
            end else begin
                win_cnt <= win_cnt + WW'(1);
                for (int i = 0; i < 6; i++)
                    lamp_cnt[i] <= cnt_nxt[i];
            end

            // A coincident error beats err_clr and restarts the count at one.
            if (err_evt) begin
                seq_error <= 1'b1;
                if (err_clr)
                    error_count <= 8'd1;
                else if (error_count != 8'hff)
                    error_count <= error_count + 8'd1;
            end else if (err_clr) begin
                seq_error   <= 1'b0;
                error_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_tail_light_monitor.sv
// Randomized bench for tail_light_monitor: reference model pushes expected frames, monitor pops on frame_valid.
module tb_tail_light_monitor;

    localparam int WINDOW     = 16;
    localparam int ON_THRESH  = 12;
    localparam int DIM_THRESH = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  light;
    logic        err_clr;
    logic        frame_valid;
    logic [11:0] lamp_state;
    logic        left_active;
    logic        right_active;
    logic [1:0]  phase;
    logic        seq_error;
    logic [7:0]  error_count;
`ifdef TAIL_DIM_CHECK_EN
    logic        dim_fault;
`endif

    always #5 clk = ~clk;

    tail_light_monitor #(
        .WINDOW(WINDOW), .ON_THRESH(ON_THRESH), .DIM_THRESH(DIM_THRESH)
    ) dut (
        .clk(clk), .reset(reset), .light(light), .err_clr(err_clr),
        .frame_valid(frame_valid), .lamp_state(lamp_state),
        .left_active(left_active), .right_active(right_active),
        .phase(phase), .seq_error(seq_error),
`ifdef TAIL_DIM_CHECK_EN
        .error_count(error_count), .dim_fault(dim_fault)
`else
        .error_count(error_count)
`endif
    );

    typedef struct {
        logic [11:0] ls;
        logic        la;
        logic        ra;
        logic [1:0]  ph;
        logic        se;
        logic [7:0]  ec;
        logic        df;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: count highs per window, classify, decode by table, judge legality by direction/phase.
    int m_cnt[6];
    int m_pos, m_dir, m_ph, m_ec;
    int fdir, fph, cl;
    logic m_se, m_err, fok, anyoff;
    logic [5:0]  onm;
    logic [11:0] lsv;
    exp_t e_new;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) m_cnt[i] = 0;
            m_pos = 0; m_dir = 0; m_ph = 0; m_se = 0; m_ec = 0;
        end else begin
            m_err = 1'b0;
            for (int i = 0; i < 6; i++) m_cnt[i] += int'(light[i]);
            m_pos++;
            if (m_pos == WINDOW) begin
                onm = '0; lsv = '0; anyoff = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    cl = (m_cnt[i] >= ON_THRESH) ? 2 : (m_cnt[i] >= DIM_THRESH) ? 1 : 0;
                    lsv[2*i +: 2] = 2'(cl);
                    onm[i] = (cl == 2);
                    if (cl == 0) anyoff = 1'b1;
                end
                fok = 1'b1; fdir = 0; fph = 0;
                case (onm)
                    6'b000000: begin fdir = 0; fph = 0; end
                    6'b001000: begin fdir = 1; fph = 1; end
                    6'b011000: begin fdir = 1; fph = 2; end
                    6'b111000: begin fdir = 1; fph = 3; end
                    6'b000100: begin fdir = 2; fph = 1; end
                    6'b000110: begin fdir = 2; fph = 2; end
                    6'b000111: begin fdir = 2; fph = 3; end
                    default:   fok = 1'b0;
                endcase
                m_err = !(fok && (fph == 0 ||
                                  (fdir == m_dir && (fph == m_ph || fph == m_ph + 1)) ||
                                  (m_dir == 0 && fph == 1)));
                m_dir = fok ? fdir : 0;
                m_ph  = fok ? fph  : 0;
                for (int i = 0; i < 6; i++) m_cnt[i] = 0;
                m_pos = 0;
            end
            if (m_err) begin
                m_se = 1'b1;
                m_ec = err_clr ? 1 : (m_ec < 255 ? m_ec + 1 : 255);
            end else if (err_clr) begin
                m_se = 1'b0;
                m_ec = 0;
            end
            if (m_pos == 0) begin
                e_new.ls = lsv; e_new.la = (m_dir == 1); e_new.ra = (m_dir == 2);
                e_new.ph = 2'(m_ph); e_new.se = m_se; e_new.ec = 8'(m_ec);
                e_new.df = fok && anyoff;
                sb.push_back(e_new);
            end
        end
    end

    // Monitor: every model frame must coincide with a frame_valid pulse and vice versa.
    always @(negedge clk) begin
        if (frame_valid || sb.size() != 0) begin
            check("frame_valid", int'(frame_valid), int'(sb.size() != 0));
            if (frame_valid && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("lamp_state", int'(lamp_state), int'(e.ls));
                check("left_active", int'(left_active), int'(e.la));
                check("right_active", int'(right_active), int'(e.ra));
                check("phase", int'(phase), int'(e.ph));
                check("seq_error", int'(seq_error), int'(e.se));
                check("error_count", int'(error_count), int'(e.ec));
`ifdef TAIL_DIM_CHECK_EN
                check("dim_fault", int'(dim_fault), int'(e.df));
`endif
            end
            sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_counts(input int k[6], input int clr_at);
        int off[6];
        for (int i = 0; i < 6; i++) off[i] = $urandom_range(WINDOW - 1, 0);
        for (int j = 0; j < WINDOW; j++) begin
            for (int i = 0; i < 6; i++) light[i] = (((j + off[i]) % WINDOW) < k[i]);
            err_clr = (j == clr_at);
            step();
        end
        err_clr = 1'b0;
    endtask

    task automatic run_window(input logic [5:0] on_m, input logic [5:0] dim_m, input int clr_at);
        int k[6];
        for (int i = 0; i < 6; i++)
            k[i] = on_m[i]  ? int'($urandom_range(WINDOW, ON_THRESH)) :
                   dim_m[i] ? int'($urandom_range(ON_THRESH - 1, DIM_THRESH)) : 0;
        run_counts(k, clr_at);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pats[7];
        int k[6];
        int n;
        pats = '{6'b000000, 6'b001000, 6'b011000, 6'b111000, 6'b000100, 6'b000110, 6'b000111};
        reset = 1'b1; light = '0; err_clr = 1'b0;
        repeat (3) step();
        check("rst_frame_valid", int'(frame_valid), 0);
        check("rst_lamp_state", int'(lamp_state), 0);
        check("rst_left", int'(left_active), 0);
        check("rst_right", int'(right_active), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_seq_error", int'(seq_error), 0);
        check("rst_error_count", int'(error_count), 0);
        reset = 1'b0;

        repeat (2) run_window(6'b000000, 6'b000000, -1);
        check("off_lamp_state", int'(lamp_state), 0);

        // Left sequence, each frame held for two windows.
        repeat (2) run_window(6'b001000, 6'b110111, -1);
        check("l1_phase", int'(phase), 1);
        repeat (2) run_window(6'b011000, 6'b100111, -1);
        check("l2_phase", int'(phase), 2);
        repeat (2) run_window(6'b111000, 6'b000111, -1);
        check("l3_phase", int'(phase), 3);
        check("l3_left", int'(left_active), 1);
        repeat (2) run_window(6'b000000, 6'b111111, -1);
        check("seq_idle_left", int'(left_active), 0);
        check("seq_error_count", int'(error_count), 0);

        // Exact PWM duty on RC.
        k = '{4, 0, 0, 0, 0, 0};  run_counts(k, -1);
        check("pwm4_dim", int'(lamp_state[1:0]), 1);
        k = '{12, 0, 0, 0, 0, 0}; run_counts(k, -1);
        check("pwm12_on", int'(lamp_state[1:0]), 2);
        k = '{11, 0, 0, 0, 0, 0}; run_counts(k, -1);
        check("pwm11_dim", int'(lamp_state[1:0]), 1);
        k = '{0, 0, 0, 0, 0, 0};  run_counts(k, -1);
        check("pwm0_off", int'(lamp_state[1:0]), 0);

        // err_clr alone, then illegal jumps.
        run_window(6'b000000, 6'b000000, 5);
        check("clr_seq_error", int'(seq_error), 0);
        check("clr_error_count", int'(error_count), 0);
        run_window(6'b001000, 6'b000000, -1);
        run_window(6'b000100, 6'b000000, -1);
        check("jump_seq_error", int'(seq_error), 1);
        check("jump_error_count", int'(error_count), 1);
        check("jump_right_r1", int'(right_active), 1);
        run_window(6'b010000, 6'b000000, -1);
        check("illegal_error_count", int'(error_count), 2);
        check("illegal_idle_phase", int'(phase), 0);

        // err_clr on the same edge as an erroring frame.
        run_window(6'b100001, 6'b000000, WINDOW - 1);
        check("clr_vs_err_seq", int'(seq_error), 1);
        check("clr_vs_err_count", int'(error_count), 1);

        // Reset part-way into a window discards the partial window.
        for (int j = 0; j < 7; j++) begin light = 6'($urandom); step(); end
        reset = 1'b1; step(); reset = 1'b0; light = '0;
        n = 0;
        while (!frame_valid && n < 3 * WINDOW) begin step(); n++; end
        check("rst_realign", n, WINDOW);
        check("rst_mid_count", int'(error_count), 0);

        // Saturation of error_count.
        for (int w = 0; w < 260; w++)
            run_window((w % 2) ? 6'b010000 : 6'b100001, 6'b000000, -1);
        check("sat_error_count", int'(error_count), 255);

        // Randomized frames, dim/off mixes, and occasional err_clr.
        for (int w = 0; w < 80; w++) begin
            int sel;
            logic [5:0] on_m;
            sel  = $urandom_range(8, 0);
            on_m = (sel >= 7) ? 6'($urandom) : pats[sel];
            run_window(on_m, 6'($urandom),
                       ($urandom_range(7, 0) == 0) ? int'($urandom_range(WINDOW - 1, 0)) : -1);
        end

        repeat (3) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
